// File: rtl/grf_hazard_reader.sv
// Decode-side register file with writeback bypass, plus an E/M/W scoreboard
// that turns in-flight destinations into a stall and per-operand forward selects.
module grf_hazard_reader #(
  parameter int STAGES = 3,
  parameter int TW     = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [4:0]    d_rs,
  input  logic [4:0]    d_rt,
  input  logic [TW-1:0] d_tuse_rs,
  input  logic [TW-1:0] d_tuse_rt,
  input  logic [4:0]    d_dst,
  input  logic [TW-1:0] d_tnew,
  input  logic          w_en,
  input  logic [4:0]    w_adr,
  input  logic [31:0]   w_data,
  output logic [31:0]   rd1,
  output logic [31:0]   rd2,
  output logic          stall,
  output logic [1:0]    fwd_rs,
  output logic [1:0]    fwd_rt
);

  typedef enum logic [1:0] {
    FWD_RF   = 2'd0,
    FWD_E    = 2'd1,
    FWD_M    = 2'd2,
    FWD_LATE = 2'd3
  } fwd_e;

  typedef struct packed {
    logic          valid;
    logic [4:0]    adr;
    logic [TW-1:0] tnew;
  } slot_t;

  logic [31:0]             regs [32];
  slot_t [STAGES-1:0]      slots;
  logic                    stall_rs, stall_rt;
  fwd_e                    fwd_rs_c, fwd_rt_c;

  // NOTE: the register array is cleared on reset, so it maps to flops
  // rather than a RAM macro; that is the price of a defined post-reset state.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (w_en && (w_adr != 5'd0)) begin
      regs[w_adr] <= w_data;
    end
  end

  // Same-cycle writeback wins over the array so W never needs a forward path.
  assign rd1 = (d_rs == 5'd0)                ? 32'd0  :
               (w_en && (w_adr == d_rs))     ? w_data : regs[d_rs];
  assign rd2 = (d_rt == 5'd0)                ? 32'd0  :
               (w_en && (w_adr == d_rt))     ? w_data : regs[d_rt];

  function automatic logic [TW-1:0] dec_sat(input logic [TW-1:0] t);
    return (t == '0) ? '0 : t - 1'b1;
  endfunction

  // Slots keep draining while D is held; a stall only injects a bubble at E.
  always_ff @(posedge clk) begin
    if (reset) begin
      slots <= '0;
    end else begin
      if (stall) slots[0] <= '0;
      else       slots[0] <= '{valid: (d_dst != 5'd0), adr: d_dst, tnew: d_tnew};
      for (int i = 1; i < STAGES; i++) begin
        slots[i] <= '{valid: slots[i-1].valid,
                      adr:   slots[i-1].adr,
                      tnew:  dec_sat(slots[i-1].tnew)};
      end
    end
  end

  function automatic void hazard(input  slot_t [STAGES-1:0] sb,
                                 input  logic [4:0]         src,
                                 input  logic [TW-1:0]      tuse,
                                 output logic               stall_o,
                                 output fwd_e               fwd_o);
    logic          found;
    int            m_slot;
    logic [TW-1:0] m_tnew;
    found  = 1'b0;
    m_slot = 0;
    m_tnew = '0;
    // Scan oldest to youngest so the youngest match overwrites the rest.
    for (int i = STAGES - 1; i >= 0; i--) begin
      if (sb[i].valid && (sb[i].adr == src) && (src != 5'd0)) begin
        found  = 1'b1;
        m_slot = i;
        m_tnew = sb[i].tnew;
      end
    end
    stall_o = 1'b0;
    fwd_o   = FWD_RF;
    if (found && (m_slot != STAGES - 1)) begin
      if (m_tnew > tuse) begin
        stall_o = 1'b1;
        fwd_o   = FWD_LATE;
      end else if (m_tnew == '0) begin
        fwd_o = (m_slot == 0) ? FWD_E : FWD_M;
      end else begin
        fwd_o = FWD_LATE;
      end
    end
  endfunction

  always_comb begin
    hazard(slots, d_rs, d_tuse_rs, stall_rs, fwd_rs_c);
    hazard(slots, d_rt, d_tuse_rt, stall_rt, fwd_rt_c);
  end

  assign stall  = stall_rs | stall_rt;
  assign fwd_rs = fwd_rs_c;
  assign fwd_rt = fwd_rt_c;

endmodule

// File: tb/tb_grf_hazard_reader.sv
// Directed bench: stimulus pushes expected outputs into a queue, a negedge
// monitor pops and compares them against the DUT.
module tb_grf_hazard_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  d_rs, d_rt, d_dst, w_adr;
  logic [1:0]  d_tuse_rs, d_tuse_rt, d_tnew;
  logic        w_en;
  logic [31:0] w_data;
  logic [31:0] rd1, rd2;
  logic        stall;
  logic [1:0]  fwd_rs, fwd_rt;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [4:0] M_RD1 = 5'b10000;
  localparam logic [4:0] M_RD2 = 5'b01000;
  localparam logic [4:0] M_ST  = 5'b00100;
  localparam logic [4:0] M_FRS = 5'b00010;
  localparam logic [4:0] M_FRT = 5'b00001;
  localparam logic [4:0] M_ALL = 5'b11111;

  typedef struct packed {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic        stall;
    logic [1:0]  fwd_rs;
    logic [1:0]  fwd_rt;
    logic [4:0]  mask;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];

  grf_hazard_reader dut (
    .clk(clk), .reset(reset),
    .d_rs(d_rs), .d_rt(d_rt), .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt),
    .d_dst(d_dst), .d_tnew(d_tnew),
    .w_en(w_en), .w_adr(w_adr), .w_data(w_data),
    .rd1(rd1), .rd2(rd2), .stall(stall), .fwd_rs(fwd_rs), .fwd_rt(fwd_rt)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // Monitor: everything pushed during a cycle is compared on its falling edge.
  always @(negedge clk) begin
    exp_t  e;
    string nm;
    while (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      if (e.mask[4]) check({nm, ".rd1"},   rd1,           e.rd1);
      if (e.mask[3]) check({nm, ".rd2"},   rd2,           e.rd2);
      if (e.mask[2]) check({nm, ".stall"}, 32'(stall),    32'(e.stall));
      if (e.mask[1]) check({nm, ".fwd_rs"}, 32'(fwd_rs),  32'(e.fwd_rs));
      if (e.mask[0]) check({nm, ".fwd_rt"}, 32'(fwd_rt),  32'(e.fwd_rt));
    end
  end

  task automatic push_exp(input string nm, input logic [4:0] mask,
                          input logic [31:0] r1, input logic [31:0] r2,
                          input logic st, input logic [1:0] fr, input logic [1:0] ft);
    exp_t e;
    e = '{rd1: r1, rd2: r2, stall: st, fwd_rs: fr, fwd_rt: ft, mask: mask};
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_d(input logic [4:0] rs, input logic [4:0] rt,
                       input logic [1:0] tu_rs, input logic [1:0] tu_rt,
                       input logic [4:0] dst, input logic [1:0] tn);
    d_rs = rs; d_rt = rt; d_tuse_rs = tu_rs; d_tuse_rt = tu_rt;
    d_dst = dst; d_tnew = tn;
  endtask

  task automatic set_w(input logic en, input logic [4:0] adr, input logic [31:0] data);
    w_en = en; w_adr = adr; w_data = data;
  endtask

  initial begin
    reset = 1'b1;
    set_d(0, 0, 0, 0, 0, 0);
    set_w(0, 0, 0);
    tick();
    tick();
    reset = 1'b0;

    // Post-reset state
    push_exp("reset_zero", M_ALL, 0, 0, 0, 0, 0);
    tick();
    set_d(7, 31, 0, 0, 0, 0);
    push_exp("reset_regs", M_ALL, 0, 0, 0, 0, 0);
    tick();

    // Write then read, with same-cycle bypass on rt
    set_w(1, 5, 32'h0000_1234);
    set_d(0, 5, 0, 0, 0, 0);
    push_exp("wr_bypass", M_RD1 | M_RD2, 0, 32'h0000_1234, 0, 0, 0);
    tick();
    set_w(1, 6, 32'hA5A5_5A5A);
    set_d(5, 6, 0, 0, 0, 0);
    push_exp("rd_array", M_RD1 | M_RD2 | M_ST, 32'h0000_1234, 32'hA5A5_5A5A, 0, 0, 0);
    tick();

    // $0 immunity
    set_w(1, 0, 32'hFFFF_FFFF);
    set_d(0, 5, 0, 0, 0, 0);
    push_exp("zero_wr", M_ALL, 0, 32'h0000_1234, 0, 0, 0);
    tick();
    set_w(0, 0, 0);
    set_d(0, 6, 0, 0, 0, 0);
    push_exp("zero_rd", M_RD1 | M_RD2 | M_ST | M_FRS, 0, 32'hA5A5_5A5A, 0, 0, 0);
    tick();

    // Bypass takes priority over the stale array value
    set_w(1, 5, 32'h5555_5555);
    set_d(5, 0, 0, 0, 0, 0);
    push_exp("bypass_prio", M_RD1, 32'h5555_5555, 0, 0, 0, 0);
    tick();
    set_w(0, 0, 0);
    push_exp("bypass_commit", M_RD1, 32'h5555_5555, 0, 0, 0, 0);
    tick();

    // Load-use stall: tnew=2 against tuse=0
    set_d(0, 0, 0, 0, 8, 2);
    push_exp("ld_issue", M_ST, 0, 0, 0, 0, 0);
    tick();
    set_d(8, 0, 0, 0, 0, 0);
    push_exp("ld_stall_e", M_ST, 0, 0, 1, 0, 0);
    tick();
    push_exp("ld_stall_m", M_ST, 0, 0, 1, 0, 0);
    tick();
    push_exp("ld_release_w", M_ST | M_FRS | M_RD1, 0, 0, 0, 0, 0);
    tick();

    // ALU forwarding: deferred from E, then from M
    set_d(0, 0, 0, 0, 9, 1);
    push_exp("alu_issue", M_ST, 0, 0, 0, 0, 0);
    tick();
    set_d(9, 0, 1, 0, 0, 0);
    push_exp("alu_late", M_ST | M_FRS, 0, 0, 0, 3, 0);
    tick();
    push_exp("alu_from_m", M_ST | M_FRS, 0, 0, 0, 2, 0);
    tick();
    push_exp("alu_at_w", M_ST | M_FRS, 0, 0, 0, 0, 0);
    tick();

    // Boundary tnew == tuse on rt: deferred, no stall
    set_d(0, 0, 0, 0, 11, 2);
    tick();
    set_d(0, 11, 0, 2, 0, 0);
    push_exp("tnew_eq_tuse", M_ST | M_FRT, 0, 0, 0, 0, 3);
    tick();
    set_d(0, 0, 0, 0, 0, 0);
    tick();
    tick();

    // Youngest match wins: two producers of $10
    set_d(0, 0, 0, 0, 10, 0);
    tick();
    tick();
    set_d(10, 10, 0, 0, 0, 0);
    push_exp("youngest_e", M_ST | M_FRS | M_FRT, 0, 0, 0, 1, 1);
    tick();
    push_exp("older_m", M_ST | M_FRS | M_FRT, 0, 0, 0, 2, 2);
    tick();
    set_d(0, 0, 0, 0, 0, 0);
    tick();
    tick();

    // Reset during a load-use stall
    set_w(1, 8, 32'hDEAD_0008);
    tick();
    set_w(0, 0, 0);
    set_d(0, 0, 0, 0, 8, 2);
    tick();
    set_d(8, 0, 0, 0, 0, 0);
    push_exp("pre_reset_stall", M_ST | M_RD1, 32'hDEAD_0008, 0, 1, 0, 0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    push_exp("post_reset", M_ST | M_FRS | M_RD1, 0, 0, 0, 0, 0);
    tick();

    // Bounded drain of the scoreboard queue
    repeat (4) begin
      if (exp_q.size() != 0) @(negedge clk);
    end
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
